fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/risc_pkg.sv | 22 ++
 rtl/fetch_unit_if.sv | 28 ++
 rtl/fetch_unit.sv | 102 ++++++++++
 3 files changed

// File: rtl/risc_pkg.sv
// Shared processor constants, fetch FSM encoding and small helpers used
// across the core.
package risc_pkg;

    localparam int AW = 13;
    localparam int DW = 32;

    localparam logic [31:0] COUNT_MAX = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

    // Counter increment that sticks at all-ones instead of rolling over.
    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == COUNT_MAX) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bundle of the fetch unit's instruction-memory port and consumer handshake.
// master is the fetch unit side, slave the memory/decoder side.
interface fetch_unit_if #(
    parameter int AW = risc_pkg::AW,
    parameter int DW = risc_pkg::DW
);
    logic [AW-1:0] imem_addr;
    logic          imem_we;
    logic [DW-1:0] imem_din;
    logic [DW-1:0] imem_rdata;
    logic          stall;
    logic          redirect;
    logic [AW-1:0] redirect_pc;
    logic [DW-1:0] instr;
    logic [AW-1:0] instr_pc;
    logic          instr_valid;
    logic [31:0]   fetch_count;

    modport master (
        output imem_addr, imem_we, imem_din, instr, instr_pc, instr_valid, fetch_count,
        input  imem_rdata, stall, redirect, redirect_pc
    );

    modport slave (
        input  imem_addr, imem_we, imem_din, instr, instr_pc, instr_valid, fetch_count,
        output imem_rdata, stall, redirect, redirect_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage in front of a 1-cycle-latency instruction RAM.
// Presents one instruction per cycle, holds it across stalls, restarts on redirect.
module fetch_unit #(
    parameter int            AW       = risc_pkg::AW,
    parameter int            DW       = risc_pkg::DW,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clka,
    input  logic          rsta,
    output logic [AW-1:0] imem_addr,
    output logic          imem_we,
    output logic [DW-1:0] imem_din,
    input  logic [DW-1:0] imem_rdata,
    input  logic          stall,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_pc,
    output logic [DW-1:0] instr,
    output logic [AW-1:0] instr_pc,
    output logic          instr_valid,
    output logic [31:0]   fetch_count
);
    import risc_pkg::*;

    localparam logic [AW-1:0] PC_ONE = {{(AW-1){1'b0}}, 1'b1};

    fetch_state_t  state_reg;
    logic [AW-1:0] fetch_pc_reg;
    logic [AW-1:0] inflight_pc_reg;
    logic [DW-1:0] hold_instr_reg;
    logic [AW-1:0] hold_pc_reg;
    logic [31:0]   fetch_count_reg;
    logic          valid_reg;

    always_ff @(posedge clka) begin
        if (rsta) begin
            state_reg       <= BOOT;
            fetch_pc_reg    <= RESET_PC;
            inflight_pc_reg <= '0;
            hold_instr_reg  <= '0;
            hold_pc_reg     <= '0;
            fetch_count_reg <= '0;
            valid_reg       <= 1'b0;
        end else if (redirect) begin
            // The displayed instruction is squashed; hold registers are left alone.
            fetch_pc_reg <= redirect_pc;
            state_reg    <= BOOT;
            valid_reg    <= 1'b0;
        end else begin
            case (state_reg)
                BOOT: begin
                    inflight_pc_reg <= fetch_pc_reg;
                    fetch_pc_reg    <= fetch_pc_reg + PC_ONE;
                    state_reg       <= RUN;
                    valid_reg       <= 1'b1;
                end
                RUN: begin
                    if (stall) begin
                        // RAM output will move on next edge, so capture it now.
                        hold_instr_reg <= imem_rdata;
                        hold_pc_reg    <= inflight_pc_reg;
                        state_reg      <= HOLD;
                    end else begin
                        inflight_pc_reg <= fetch_pc_reg;
                        fetch_pc_reg    <= fetch_pc_reg + PC_ONE;
                        fetch_count_reg <= sat_inc(fetch_count_reg);
                    end
                    valid_reg <= 1'b1;
                end
                HOLD: begin
                    if (!stall) begin
                        // fetch_pc never moved while held, so the RAM already shows its word.
                        inflight_pc_reg <= fetch_pc_reg;
                        fetch_pc_reg    <= fetch_pc_reg + PC_ONE;
                        fetch_count_reg <= sat_inc(fetch_count_reg);
                        state_reg       <= RUN;
                    end
                    valid_reg <= 1'b1;
                end
                default: begin
                    state_reg <= BOOT;
                    valid_reg <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        instr    = imem_rdata;
        instr_pc = inflight_pc_reg;
        if (state_reg == HOLD) begin
            instr    = hold_instr_reg;
            instr_pc = hold_pc_reg;
        end
    end

    assign instr_valid = valid_reg;
    assign fetch_count = fetch_count_reg;
    assign imem_addr   = fetch_pc_reg;
    assign imem_we     = 1'b0;
    assign imem_din    = '0;

endmodule
